muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// Iterative RV32M multiply/divide unit in the execute stage, beside the ALU.
// Takes rs1/rs2 and a muldiv_type opcode (funct3 of muldiv_op) when the decoder issues an M-extension instruction.
// Produces a 32-bit result after a fixed latency; the HDU stalls the pipeline while busy_o is high.
// PARAMETERS
// DATA_W   32  operand/result width (`data_size)
// CNT_W    6   iteration counter width (log2(DATA_W)+1)
// PORTS
// clk       in   1       clock, all state updates on rising edge
// rst       in   1       synchronous, active-high reset
// start_i   in   1       issue request; sampled only in MD_IDLE
// op_i      in   3       muldiv_type (mul..remu)
// rs1_i     in   DATA_W  operand A (multiplicand/dividend)
// rs2_i     in   DATA_W  operand B (multiplier/divisor)
// flush_i   in   1       kill in-flight operation (branch mispredict/exception)
// busy_o    out  1       high from cycle after accepted start until done cycle inclusive
// done_o    out  1       one-cycle pulse, result_o valid
// result_o  out  DATA_W  result; holds value until next done_o
// BEHAVIOUR
// - Reset: state=MD_IDLE, busy_o=0, done_o=0, result_o=0, counter=0. Synchronous, clk and rst only.
// - FSM: MD_IDLE --start_i--> MD_CALC (count 0..31) --count==31--> MD_DONE --> MD_IDLE.
// - Accept at edge k: operands latched, signs recorded, magnitudes formed.
//   MD_CALC occupies 32 cycles; done_o=1 and result_o valid in cycle k+33.
//   Fixed latency for all ops (`muldiv_latency = 33), including special cases.
// - start_i outside MD_IDLE is ignored. Back-to-back: start_i in the cycle after done_o is accepted.
// - Multiply: radix-2 shift-add on 32-bit magnitudes into a 64-bit product, negated in MD_DONE when sign differs.
//   Operand signedness: mul/mulh both signed; mulhsu rs1 signed, rs2 unsigned; mulhu both unsigned.
//   Result: mul -> product[31:0]; mulh/mulhsu/mulhu -> product[63:32].
// - Divide: restoring, one quotient bit per cycle on magnitudes.
//   div/rem signed, divu/remu unsigned. Quotient sign = sA^sB; remainder sign = sA.
// - Divide by zero, decided at accept, flagged, result forced in MD_DONE:
//   quotient = 32'hFFFFFFFF; remainder = rs1_i (unmodified).
// - Signed overflow (div/rem, rs1=32'h80000000, rs2=32'hFFFFFFFF):
//   quotient = 32'h80000000, remainder = 0.
// - Magnitude of 32'h80000000 is 32'h80000000 treated unsigned (33-bit internal sign handling); no overflow.
// - flush_i: any state -> MD_IDLE next edge, no done_o, result_o unchanged.
//   flush_i with start_i in MD_IDLE: start is dropped.
//   flush_i has priority over start_i; rst has priority over all.
// - done_o never asserted two consecutive cycles.
// STRUCTURE
// - Add to shared constants package:
//   typedef enum logic[1:0] {MD_IDLE, MD_CALC, MD_DONE} muldiv_state;
//   `define muldiv_latency 33
//   Reuse muldiv_type from the package for op_i.
// - One sub-module, muldiv_step: combinational single-iteration datapath.
//   Shift-add for mul, shift-subtract-restore for div. Instanced once; FSM, counter and sign fix stay in muldiv_unit.
// TESTING
// - mul 7 * -3 (rs2=32'hFFFFFFFD): start at k -> done_o at k+33, result 32'hFFFFFFEB, busy_o high k+1..k+33.
// - mulh 32'h80000000*32'h80000000 -> 32'h40000000; mulhu 32'hFFFFFFFF*32'hFFFFFFFF -> 32'hFFFFFFFE;
//   mulhsu -1*32'hFFFFFFFF -> 32'hFFFFFFFF.
// - div -7/2 -> 32'hFFFFFFFD; rem -7/2 -> 32'hFFFFFFFF; divu 32'hFFFFFFFE/2 -> 32'h7FFFFFFF.
// - div 5/0 -> 32'hFFFFFFFF; remu 5/0 -> 5; div 32'h80000000/-1 -> 32'h80000000;
//   rem of same -> 0; all at k+33.
// - flush_i at k+10 -> no done_o, busy_o low at k+11, result_o unchanged.
//   New start at k+11 completes at k+44.
// - start_i held high continuously plus rst mid-CALC:
//   exactly one done_o per 34 cycles; rst -> busy_o=0, done_o=0, result_o=0 next edge.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
`ifndef MULDIV_LATENCY
`define MULDIV_LATENCY 33
`endif

package muldiv_unit_pkg;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_type;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } muldiv_state;

  localparam int unsigned MuldivLatency = `MULDIV_LATENCY;

  function automatic logic op_signed_a(input muldiv_type op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_type op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: shift-add multiply or restoring divide on magnitudes.
module muldiv_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] rem_sub;
  logic              fits;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    shifted = {hi_i, lo_i[DATA_W-1]};
    fits    = (shifted >= {1'b0, b_i});
    // Partial remainder is always below the divisor, so the low bits suffice.
    rem_sub = shifted[DATA_W-1:0] - b_i;
    if (is_div_i) begin
      hi_o = fits ? rem_sub : shifted[DATA_W-1:0];
      lo_o = {lo_i[DATA_W-2:0], fits};
    end else begin
      hi_o = sum[DATA_W:1];
      lo_o = {sum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed latency; FSM, counter and sign fix-up.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  muldiv_type        op_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  muldiv_state       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  muldiv_type        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0] quo_fix, rem_fix, final_res;

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // 0x80000000 negates to itself and is then read as an unsigned magnitude.
  always_comb begin
    a_neg = op_signed_a(op_i) & rs1_i[DATA_W-1];
    b_neg = op_signed_b(op_i) & rs2_i[DATA_W-1];
    a_mag = a_neg ? -rs1_i : rs1_i;
    b_mag = b_neg ? -rs2_i : rs2_i;
  end

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_fix  = dz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -step_lo : step_lo);
    rem_fix  = neg_a_q ? -step_hi : step_hi;
    unique case (op_q)
      MUL:                 final_res = prod_fix[DATA_W-1:0];
      MULH, MULHSU, MULHU: final_res = prod_fix[2*DATA_W-1:DATA_W];
      DIV, DIVU:           final_res = quo_fix;
      REM, REMU:           final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    result_d = result_q;
    if (flush_i) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_d = MD_CALC;
            cnt_d   = '0;
            op_d    = op_i;
            neg_a_d = a_neg;
            neg_b_d = b_neg;
            dz_d    = op_i[2] && (rs2_i == '0);
            hi_d    = '0;
            // Divide iterates over the dividend; multiply over the multiplier.
            lo_d    = op_i[2] ? a_mag : b_mag;
            b_d     = op_i[2] ? b_mag : a_mag;
          end
        end
        MD_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = MD_DONE;
            result_d = final_res;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != MD_IDLE);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, flush and reset behaviour.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  muldiv_type  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        flush_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  int dn, first_d, last_d;
  bit consec;
  logic prev_done;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the unit idle; start is sampled at the next edge (cycle k).
  task automatic do_op(input string tag, input muldiv_type op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int  done_at;
    bit  busy_ok;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    done_at = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1;
      if (done_o && done_at < 0) done_at = i;
      if (i <= 32 && !busy_o) busy_ok = 1'b0;
      if (i == 32) check_eq({tag, " result"}, result_o, exp);
    end
    // i == 32 is cycle k+33
    check_eq({tag, " latency"}, done_at, 32);
    check_eq({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check_eq({tag, " idle after"}, {30'd0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = MUL;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset done", {31'd0, done_o}, 32'd0);
    check_eq("reset result", result_o, 32'd0);

    do_op("mul 7*-3", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    do_op("mulh min*min", MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    do_op("mulhu max*max", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_op("mulhsu -1*max", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op("div -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    do_op("rem -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    do_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF);
    do_op("remu 5/0", REMU, 32'd5, 32'd0, 32'd5);
    do_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    do_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    do_op("divu max-1/2", DIVU, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF);

    // Flush in cycle k+10 of a divide
    op_i    = DIV;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check_eq("flush busy", {31'd0, busy_o}, 32'd0);
    check_eq("flush done", {31'd0, done_o}, 32'd0);
    check_eq("flush result held", result_o, 32'h7FFFFFFF);
    do_op("div 100/7 after flush", DIV, 32'd100, 32'd7, 32'd14);

    // Flush beats start in idle
    op_i    = MUL;
    rs1_i   = 32'd3;
    rs2_i   = 32'd4;
    start_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    flush_i = 1'b0;
    check_eq("flush drops start", {31'd0, busy_o}, 32'd0);

    // Start held high: one done per 34 cycles, then reset mid-calculation
    op_i    = MUL;
    rs1_i   = 32'd7;
    rs2_i   = 32'hFFFFFFFD;
    start_i = 1'b1;
    dn = 0;
    first_d = -1;
    last_d = -1;
    consec = 1'b0;
    prev_done = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        if (prev_done) consec = 1'b1;
        if (first_d < 0) first_d = i;
        last_d = i;
        dn++;
      end
      prev_done = done_o;
    end
    check_eq("held start done count", dn, 3);
    check_eq("held start first done", first_d, 33);
    check_eq("held start period", last_d - first_d, 68);
    check_eq("held start no double done", {31'd0, consec}, 32'd0);
    check_eq("held start result", result_o, 32'hFFFFFFEB);
    check_eq("held start busy mid calc", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start_i = 1'b0;
    check_eq("mid rst busy", {31'd0, busy_o}, 32'd0);
    check_eq("mid rst done", {31'd0, done_o}, 32'd0);
    check_eq("mid rst result", result_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
